// File: rtl/key_expand_seq.sv
// Iterative AES key expander for 128/192/256-bit keys: one schedule word per clock
// into a local word store, with any 128-bit round key readable combinationally.
module key_expand_seq #(
  parameter int unsigned MAX_KEY_BITS    = 256,
  parameter bit          RD_ZERO_INVALID = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         abort,
  output logic         busy,
  output logic         keys_valid,
  output logic         key_err,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  localparam int unsigned MAX_NR  = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
  localparam int unsigned DEPTH   = 4 * (MAX_NR + 1);
  localparam logic [6:0]  DEPTH_W = 7'(DEPTH);

  typedef enum logic {StIdle, StExpand} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t       r_state, w_state_nxt;
  logic [5:0]   r_i;
  logic [2:0]   r_j;
  logic [7:0]   r_rcon;
  logic [3:0]   r_nk, r_nr;
  logic         r_keys_valid, r_key_err;
  logic [31:0]  r_store [DEPTH];

  logic         w_accept, w_len_ok, w_load, w_bad, w_last, w_step, w_rd_ok;
  logic [3:0]   w_nk_in, w_nr_in;
  logic [5:0]   w_total, w_rd_base, w_idx;
  logic [31:0]  w_prev, w_back, w_temp, w_new;
  logic [127:0] w_rd_words;

  always_comb begin
    w_len_ok = 1'b0;
    w_nk_in  = 4'd4;
    w_nr_in  = 4'd10;
    case (key_len)
      2'd0: w_len_ok = 1'b1;
      2'd1: begin
        w_len_ok = (MAX_KEY_BITS >= 192);
        w_nk_in  = 4'd6;
        w_nr_in  = 4'd12;
      end
      2'd2: begin
        w_len_ok = (MAX_KEY_BITS >= 256);
        w_nk_in  = 4'd8;
        w_nr_in  = 4'd14;
      end
      default: w_len_ok = 1'b0;
    endcase
  end

  assign w_accept = key_valid && (r_state == StIdle);
  assign w_load   = w_accept && w_len_ok;
  assign w_bad    = w_accept && !w_len_ok;
  assign w_total  = {r_nr, 2'b00} + 6'd4;
  assign w_last   = (r_i == w_total - 6'd1);
  assign w_step   = (r_state == StExpand) && !abort;

  assign w_prev = r_store[r_i - 6'd1];
  assign w_back = r_store[r_i - {2'b00, r_nk}];

  always_comb begin
    w_temp = w_prev;
    if (r_j == 3'd0) begin
      w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    end else if (r_nk == 4'd8 && r_j == 3'd4) begin
      w_temp = sub_word(w_prev);
    end
  end
  assign w_new = w_back ^ w_temp;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_load) w_state_nxt = StExpand;
      StExpand: if (abort || w_last) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_i          <= '0;
      r_j          <= '0;
      r_rcon       <= 8'h01;
      r_nk         <= 4'd4;
      r_nr         <= '0;
      r_keys_valid <= 1'b0;
      r_key_err    <= 1'b0;
    end else begin
      r_key_err <= w_bad;
      if (w_load) begin
        r_i          <= {2'b00, w_nk_in};
        r_j          <= '0;
        r_rcon       <= 8'h01;
        r_nk         <= w_nk_in;
        r_nr         <= w_nr_in;
        r_keys_valid <= 1'b0;
      end else if (w_step) begin
        r_i <= r_i + 6'd1;
        r_j <= ({1'b0, r_j} == r_nk - 4'd1) ? 3'd0 : r_j + 3'd1;
        if (r_j == 3'd0) r_rcon <= xtime(r_rcon);
        if (w_last) r_keys_valid <= 1'b1;
      end
    end
  end

  // Store has no reset: its contents only matter once keys_valid is set.
  always_ff @(posedge clock) begin
    if (w_load) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < w_nk_in) r_store[6'(k)] <= key_in[255 - 32*k -: 32];
      end
    end else if (w_step) begin
      r_store[r_i] <= w_new;
    end
  end

  assign w_rd_base = {rd_round, 2'b00};
  always_comb begin
    w_rd_words = '0;
    w_idx      = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_rd_base + 6'(k);
      if ({1'b0, w_idx} < DEPTH_W) w_rd_words[127 - 32*k -: 32] = r_store[w_idx];
    end
  end

  assign w_rd_ok    = r_keys_valid && (rd_round <= r_nr);
  assign rd_key     = (RD_ZERO_INVALID && !w_rd_ok) ? '0 : w_rd_words;
  assign key_ready  = (r_state == StIdle);
  assign busy       = (r_state == StExpand);
  assign keys_valid = r_keys_valid;
  assign key_err    = r_key_err;
  assign num_rounds = r_nr;

endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: known-answer table, corner sequences, and random keys
// checked against a FIPS-197 style schedule model built from a searched sbox.
module tb_key_expand_seq;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         key_valid, key_valid2, abort;
  logic [3:0]   rd_round;

  logic         key_ready, busy, keys_valid, key_err;
  logic [3:0]   num_rounds;
  logic [127:0] rd_key;
  logic         key_ready_b, busy_b, keys_valid_b, key_err_b;
  logic [3:0]   num_rounds_b;
  logic [127:0] rd_key_b;

  always #5 clock = ~clock;

  key_expand_seq #(.MAX_KEY_BITS(256), .RD_ZERO_INVALID(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .key_in(key_in), .key_len(key_len),
    .key_valid(key_valid), .key_ready(key_ready), .abort(abort), .busy(busy),
    .keys_valid(keys_valid), .key_err(key_err), .num_rounds(num_rounds),
    .rd_round(rd_round), .rd_key(rd_key)
  );

  key_expand_seq #(.MAX_KEY_BITS(128), .RD_ZERO_INVALID(1'b1)) dut_b (
    .clock(clock), .reset_n(reset_n), .key_in(key_in), .key_len(key_len),
    .key_valid(key_valid2), .key_ready(key_ready_b), .abort(abort), .busy(busy_b),
    .keys_valid(keys_valid_b), .key_err(key_err_b), .num_rounds(num_rounds_b),
    .rd_round(rd_round), .rd_key(rd_key_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sb [256];
  logic [31:0] ref_w [60];
  int          ref_nr;
  int          ref_edges;

  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int k = 0; k < 8; k++) if (((b >> k) & 1) == 1) p = p ^ (a << k);
    for (int k = 14; k >= 8; k--) if (((p >> k) & 1) == 1) p = p ^ ('h11b << (k - 8));
    return p;
  endfunction

  task automatic build_sbox();
    int inv, s, v;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
      s = 0;
      for (int i = 0; i < 8; i++) begin
        v = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
             (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (v << i);
      end
      sb[x] = s[7:0];
    end
  endtask

  function automatic logic [31:0] subw_ref(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int len);
    int nk, tot, rc;
    logic [31:0] t;
    nk = 4 + 2 * len;
    ref_nr = nk + 6;
    tot = 4 * (ref_nr + 1);
    ref_edges = tot - nk;
    rc = 1;
    for (int i = 0; i < 60; i++) ref_w[i] = '0;
    for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < tot; i++) begin
      t = ref_w[i - 1];
      if (i % nk == 0) begin
        t = subw_ref({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h0};
        rc = gmul(rc, 2);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw_ref(t);
      end
      ref_w[i] = ref_w[i - nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    if (r > ref_nr) return '0;
    return {ref_w[4*r], ref_w[4*r + 1], ref_w[4*r + 2], ref_w[4*r + 3]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [255:0] key, input logic [1:0] len, input bit second);
    @(negedge clock);
    key_in  = key;
    key_len = len;
    if (second) key_valid2 = 1'b1;
    else        key_valid  = 1'b1;
    @(posedge clock);
    #1;
    key_valid  = 1'b0;
    key_valid2 = 1'b0;
  endtask

  task automatic wait_done(input bit second, output int edges);
    bit done;
    done  = 1'b0;
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clock);
      #1;
      edges++;
      done = second ? keys_valid_b : keys_valid;
    end
    chk("done_within_bound", 128'(done), 128'd1);
  endtask

  task automatic check_schedule(input string tag);
    for (int r = 0; r < 16; r++) begin
      @(negedge clock);
      rd_round = 4'(r);
      #1;
      chk($sformatf("%s_rk%0d", tag, r), rd_key, exp_rk(r));
    end
  endtask

  typedef struct {
    logic [255:0] key;
    logic [1:0]   len;
    int           edges;
    logic [3:0]   rnd;
    logic [127:0] rk;
    logic [3:0]   wr;
    int           ws;
    logic [31:0]  wexp;
  } kat_t;

  kat_t kat [4];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    int edges;
    int len;
    logic [255:0] rkey;
    logic [127:0] held;

    kat[0] = '{K128, 2'd0, 40, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 4'd1, 0, 32'ha0fafe17};
    kat[1] = '{K128, 2'd0, 40, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd1, 3, 32'h2a6c7605};
    kat[2] = '{K192, 2'd1, 46, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 4'd1, 2, 32'hfe0c91f7};
    kat[3] = '{K256, 2'd2, 52, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 4'd2, 0, 32'h9ba35411};

    build_sbox();

    reset_n = 1'b0; key_in = '0; key_len = '0; key_valid = 1'b0; key_valid2 = 1'b0;
    abort = 1'b0; rd_round = '0;
    #12;
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_keys_valid", 128'(keys_valid), 128'd0);
    chk("rst_key_err", 128'(key_err), 128'd0);
    chk("rst_num_rounds", 128'(num_rounds), 128'd0);
    chk("rst_rd_key", rd_key, 128'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Known-answer table.
    for (int e = 0; e < 4; e++) begin
      model_expand(kat[e].key, int'(kat[e].len));
      do_load(kat[e].key, kat[e].len, 1'b0);
      chk($sformatf("kat%0d_busy", e), 128'(busy), 128'd1);
      chk($sformatf("kat%0d_kv_low", e), 128'(keys_valid), 128'd0);
      wait_done(1'b0, edges);
      chk($sformatf("kat%0d_edges", e), 128'(edges), 128'(kat[e].edges));
      chk($sformatf("kat%0d_nr", e), 128'(num_rounds), 128'(10 + 2 * int'(kat[e].len)));
      @(negedge clock);
      rd_round = kat[e].rnd;
      #1;
      chk($sformatf("kat%0d_rk", e), rd_key, kat[e].rk);
      @(negedge clock);
      rd_round = kat[e].wr;
      #1;
      chk($sformatf("kat%0d_word", e), 128'(rd_key[127 - 32*kat[e].ws -: 32]), 128'(kat[e].wexp));
      check_schedule($sformatf("kat%0d", e));
    end

    // Illegal length while a 256-bit schedule is held.
    @(negedge clock);
    rd_round = 4'd14;
    do_load(K128, 2'd3, 1'b0);
    chk("err3_pulse", 128'(key_err), 128'd1);
    chk("err3_ready", 128'(key_ready), 128'd1);
    chk("err3_kv", 128'(keys_valid), 128'd1);
    chk("err3_nr", 128'(num_rounds), 128'd14);
    chk("err3_rk", rd_key, kat[3].rk);
    @(posedge clock);
    #1;
    chk("err3_one_cycle", 128'(key_err), 128'd0);
    chk("err3_not_busy", 128'(busy), 128'd0);

    // Unsupported length on the 128-bit-only instance.
    do_load(K128, 2'd0, 1'b1);
    wait_done(1'b1, edges);
    chk("b_edges", 128'(edges), 128'd40);
    @(negedge clock);
    rd_round = 4'd10;
    do_load(K256, 2'd2, 1'b1);
    chk("b_err_pulse", 128'(key_err_b), 128'd1);
    chk("b_err_ready", 128'(key_ready_b), 128'd1);
    chk("b_err_kv", 128'(keys_valid_b), 128'd1);
    chk("b_err_nr", 128'(num_rounds_b), 128'd10);
    chk("b_err_rk", rd_key_b, kat[1].rk);
    @(posedge clock);
    #1;
    chk("b_err_one_cycle", 128'(key_err_b), 128'd0);

    // Abort on expand edge 20.
    model_expand(K128, 0);
    do_load(K128, 2'd0, 1'b0);
    repeat (19) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    rd_round = 4'd1;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_ready", 128'(key_ready), 128'd1);
    chk("abort_kv", 128'(keys_valid), 128'd0);
    chk("abort_rk_zero", rd_key, 128'd0);

    // Reload, with a key_valid pulse mid-expansion that must be ignored.
    do_load(K128, 2'd0, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    key_in = K256;
    key_len = 2'd2;
    key_valid = 1'b1;
    @(posedge clock);
    #1;
    key_valid = 1'b0;
    chk("ignored_busy", 128'(busy), 128'd1);
    wait_done(1'b0, edges);
    chk("reload_edges", 128'(edges + 6), 128'd40);
    check_schedule("reload");

    // Asynchronous reset in the middle of an expansion.
    model_expand(K256, 2);
    do_load(K256, 2'd2, 1'b0);
    repeat (10) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", 128'(key_ready), 128'd1);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_kv", 128'(keys_valid), 128'd0);
    chk("arst_nr", 128'(num_rounds), 128'd0);
    @(negedge clock);
    reset_n = 1'b1;

    model_expand(K128, 0);
    do_load(K128, 2'd0, 1'b0);
    wait_done(1'b0, edges);
    @(negedge clock);
    rd_round = 4'd15;
    #1;
    chk("rd15_zero", rd_key, 128'd0);

    // Random keys of random length; LSBs beyond Nk words are garbage.
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 8; k++) rkey[32*k +: 32] = $urandom;
      len = $urandom_range(0, 2);
      model_expand(rkey, len);
      do_load(rkey, 2'(len), 1'b0);
      wait_done(1'b0, edges);
      chk($sformatf("rnd%0d_edges", t), 128'(edges), 128'(ref_edges));
      chk($sformatf("rnd%0d_nr", t), 128'(num_rounds), 128'(ref_nr));
      check_schedule($sformatf("rnd%0d", t));
    end

    held = rd_key;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
